// File: rtl/adc14_to_axis_m.sv
// ADC receive front end: registers the 14-bit offset-binary ADC bus, converts to two's complement
// and streams fixed-length packets out through a first-word-fall-through FIFO.
module adc14_to_axis_m #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int PACKET_LEN           = 1024,
  parameter int FIFO_DEPTH_LOG2      = 4
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  input  logic                                streamEnable,
  input  logic                                testMode,
  input  logic [13:0]                         ADC_data,
  input  logic                                ADC_otr,
  output logic                                ClockToADC,
  output logic [2:0]                          state,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int PKT_W = (PACKET_LEN > 2) ? $clog2(PACKET_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    TEST   = 2'b10
  } fsm_t;

  function automatic logic signed [15:0] offset_to_twos(input logic [13:0] d);
    logic [13:0] s;
    s = {~d[13], d[12:0]};
    return {{2{s[13]}}, s};
  endfunction

  function automatic logic signed [15:0] sext14(input logic [13:0] c);
    return {{2{c[13]}}, c};
  endfunction

  fsm_t                     fsm, fsm_nxt;
  logic                     overflow;
  logic [PKT_W-1:0]         pkt_cnt;
  logic [13:0]              test_cnt;
  logic [13:0]              adc_data_p0;
  logic                     adc_otr_p0;
  logic signed [15:0]       sample_p0;
  logic                     otr_src;
  logic [17:0]              mem [DEPTH];
  logic [17:0]              head;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     full, wr_acc, rd_en, pkt_last;

  // ODDR with D1=0, D2=1 drives the inverse of the fabric clock; no reset involvement.
  assign ClockToADC = ~M_AXIS_ACLK;

  // Stage A: IOB capture of the ADC pins, every edge
  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      adc_data_p0 <= '0;
      adc_otr_p0  <= 1'b0;
    end else begin
      adc_data_p0 <= ADC_data;
      adc_otr_p0  <= ADC_otr;
    end
  end

  always_comb begin
    sample_p0 = offset_to_twos(adc_data_p0);
    otr_src   = adc_otr_p0;
    if (fsm == TEST) begin
      sample_p0 = sext14(test_cnt);
      otr_src   = 1'b0;
    end
  end

  // Fullness is judged before the same-edge pop, so a full FIFO drops even while draining.
  assign full     = (count == CNT_W'(DEPTH));
  assign wr_acc   = (fsm != IDLE) && !full;
  assign rd_en    = (count != '0) && M_AXIS_TREADY;
  assign pkt_last = (pkt_cnt == PKT_W'(PACKET_LEN - 1));

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: begin
        if (testMode)          fsm_nxt = TEST;
        else if (streamEnable) fsm_nxt = STREAM;
      end
      STREAM: if (wr_acc && pkt_last && !streamEnable) fsm_nxt = IDLE;
      TEST:   if (wr_acc && pkt_last && !testMode)     fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      fsm      <= IDLE;
      overflow <= 1'b0;
      pkt_cnt  <= '0;
      test_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      fsm <= fsm_nxt;
      if ((fsm != IDLE) && full) overflow <= 1'b1;

      if (fsm == IDLE)  pkt_cnt <= '0;
      else if (wr_acc)  pkt_cnt <= pkt_last ? '0 : pkt_cnt + 1'b1;

      if ((fsm == IDLE) && (fsm_nxt == TEST)) test_cnt <= '0;
      else if ((fsm == TEST) && wr_acc)       test_cnt <= test_cnt + 1'b1;

      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: {tlast, otr, sample}
  always_ff @(posedge M_AXIS_ACLK) begin
    if (wr_acc) mem[wr_ptr] <= {pkt_last, otr_src, sample_p0};
  end

  assign head          = mem[rd_ptr];
  assign M_AXIS_TVALID = (count != '0);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? {{(C_M_AXIS_TDATA_WIDTH-17){1'b0}}, head[16:0]} : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID && head[17];
  assign M_AXIS_TSTRB  = '1;
  assign state         = {overflow, fsm};

endmodule

// File: tb/tb_adc14_to_axis_m.sv
// Directed bench for adc14_to_axis_m with 8-sample packets and a 4-entry FIFO.
module tb_adc14_to_axis_m;
  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        streamEnable, testMode, ADC_otr, tready;
  logic [13:0] ADC_data;
  logic        ClockToADC, tvalid, tlast;
  logic [2:0]  state;
  logic [W-1:0] tdata;
  logic [W/8-1:0] tstrb;

  int total = 0;
  int bad   = 0;
  logic [31:0] got_d[$];
  logic        got_l[$];

  adc14_to_axis_m #(
    .C_M_AXIS_TDATA_WIDTH(W),
    .PACKET_LEN(8),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESET(rst),
    .streamEnable(streamEnable),
    .testMode(testMode),
    .ADC_data(ADC_data),
    .ADC_otr(ADC_otr),
    .ClockToADC(ClockToADC),
    .state(state),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TDATA(tdata),
    .M_AXIS_TSTRB(tstrb),
    .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Records a handshake at the falling edge, then advances to 1 ns past the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (tvalid && tready) begin
      got_d.push_back(tdata);
      got_l.push_back(tlast);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    streamEnable = 1'b0; testMode = 1'b0;
    ADC_data = '0; ADC_otr = 1'b0; tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_d.delete(); got_l.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    streamEnable = 1'b0; testMode = 1'b0;
    ADC_data = '0; ADC_otr = 1'b0; tready = 1'b1;
    #1;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    total++; if (tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h exp=00000000", tdata); end
    total++; if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", tlast); end
    total++; if (state !== 3'b000) begin bad++; $display("FAIL reset_state got=%b exp=000", state); end
    total++; if (tstrb !== 4'hF) begin bad++; $display("FAIL reset_tstrb got=%h exp=f", tstrb); end
    @(negedge clk); #1;
    total++; if (ClockToADC !== 1'b1) begin bad++; $display("FAIL clk_to_adc_low got=%b exp=1", ClockToADC); end
    @(posedge clk); #1;
    total++; if (ClockToADC !== 1'b0) begin bad++; $display("FAIL clk_to_adc_high got=%b exp=0", ClockToADC); end
    rst = 1'b0;
    got_d.delete(); got_l.delete();
  endtask

  task automatic test_ramp();
    got_d.delete(); got_l.delete();
    tready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      streamEnable = (c == 0);
      ADC_data = 14'(c);
      ADC_otr = 1'b0;
      tick();
    end
    total++; if (got_d.size() != 8) begin bad++; $display("FAIL ramp_count got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      total++;
      if (got_d[i] !== 32'h0000E000 + 32'(i)) begin bad++; $display("FAIL ramp_data[%0d] got=%h exp=%h", i, got_d[i], 32'h0000E000 + 32'(i)); end
      total++;
      if (got_l[i] !== (i == 7)) begin bad++; $display("FAIL ramp_last[%0d] got=%b exp=%b", i, got_l[i], (i == 7)); end
    end
    total++; if (state !== 3'b000) begin bad++; $display("FAIL ramp_state got=%b exp=000", state); end
  endtask

  task automatic test_convert();
    logic [14:0] vec [8];
    logic [31:0] exp [8];
    vec[0] = {1'b1, 14'h2000}; exp[0] = 32'h0001_0000;
    vec[1] = {1'b0, 14'h3FFF}; exp[1] = 32'h0000_1FFF;
    vec[2] = {1'b0, 14'h0000}; exp[2] = 32'h0000_E000;
    for (int i = 3; i < 8; i++) begin vec[i] = {1'b0, 14'h1000}; exp[i] = 32'h0000_F000; end
    got_d.delete(); got_l.delete();
    tready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      streamEnable = (c == 0);
      {ADC_otr, ADC_data} = (c < 8) ? vec[c] : 15'h0;
      tick();
    end
    ADC_otr = 1'b0;
    total++; if (got_d.size() != 8) begin bad++; $display("FAIL conv_count got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      total++;
      if (got_d[i] !== exp[i]) begin bad++; $display("FAIL conv_data[%0d] got=%h exp=%h", i, got_d[i], exp[i]); end
    end
  endtask

  task automatic test_testmode();
    got_d.delete(); got_l.delete();
    tready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      testMode = (c < 20);
      ADC_data = 14'h1555;
      tick();
    end
    total++; if (got_d.size() != 24) begin bad++; $display("FAIL tm_count got=%0d exp=24", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 24; i++) begin
      total++;
      if (got_d[i] !== 32'(i)) begin bad++; $display("FAIL tm_data[%0d] got=%h exp=%h", i, got_d[i], 32'(i)); end
      total++;
      if (got_l[i] !== ((i % 8) == 7)) begin bad++; $display("FAIL tm_last[%0d] got=%b exp=%b", i, got_l[i], ((i % 8) == 7)); end
    end
    total++; if (state !== 3'b000) begin bad++; $display("FAIL tm_state got=%b exp=000", state); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp [8];
    for (int i = 0; i < 4; i++) exp[i] = 32'h0000E000 + 32'(i);
    for (int i = 4; i < 8; i++) exp[i] = 32'h0000E000 + 32'(i + 10);
    got_d.delete(); got_l.delete();
    for (int c = 0; c < 32; c++) begin
      streamEnable = (c < 10);
      ADC_data = 14'(c);
      tready = (c >= 14);
      if (c == 12) begin
        total++; if (state !== 3'b101) begin bad++; $display("FAIL ovf_state_stalled got=%b exp=101", state); end
        total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL ovf_tvalid_stalled got=%b exp=1", tvalid); end
        total++; if (tdata !== 32'h0000E000) begin bad++; $display("FAIL ovf_tdata_stalled got=%h exp=0000e000", tdata); end
      end
      tick();
    end
    total++; if (got_d.size() != 8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", got_d.size()); end
    for (int i = 0; i < got_d.size() && i < 8; i++) begin
      total++;
      if (got_d[i] !== exp[i]) begin bad++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, got_d[i], exp[i]); end
      total++;
      if (got_l[i] !== (i == 7)) begin bad++; $display("FAIL ovf_last[%0d] got=%b exp=%b", i, got_l[i], (i == 7)); end
    end
    total++; if (state !== 3'b100) begin bad++; $display("FAIL ovf_state_end got=%b exp=100", state); end
  endtask

  task automatic test_random_ready();
    logic        prev_stall;
    logic [31:0] prev_d;
    logic        prev_l;
    int          n;
    prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    got_d.delete(); got_l.delete();
    for (int c = 0; c < 160; c++) begin
      streamEnable = (c < 40);
      ADC_data = 14'(c);
      tready = (c >= 140) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        total++;
        if (tvalid !== 1'b1 || tdata !== prev_d || tlast !== prev_l) begin
          bad++;
          $display("FAIL stall_hold c=%0d got=%b/%h/%b exp=1/%h/%b", c, tvalid, tdata, tlast, prev_d, prev_l);
        end
      end
      if (tvalid && tready) begin
        got_d.push_back(tdata);
        got_l.push_back(tlast);
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
      @(posedge clk);
      #1;
    end
    n = got_d.size();
    total++; if (n == 0 || (n % 8) != 0) begin bad++; $display("FAIL rnd_count got=%0d exp=nonzero multiple of 8", n); end
    total++; if (n > 0 && got_d[0] !== 32'h0000E000) begin bad++; $display("FAIL rnd_first got=%h exp=0000e000", got_d[0]); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_l[i] !== ((i % 8) == 7)) begin bad++; $display("FAIL rnd_last[%0d] got=%b exp=%b", i, got_l[i], ((i % 8) == 7)); end
      if (i > 0) begin
        total++;
        if (got_d[i] <= got_d[i-1]) begin bad++; $display("FAIL rnd_order[%0d] got=%h exp=above %h", i, got_d[i], got_d[i-1]); end
      end
      if (state[2] == 1'b0) begin
        total++;
        if (got_d[i] !== 32'h0000E000 + 32'(i)) begin bad++; $display("FAIL rnd_contig[%0d] got=%h exp=%h", i, got_d[i], 32'h0000E000 + 32'(i)); end
      end
    end
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rnd_drained got=%b exp=0", tvalid); end
    total++; if (state[1:0] !== 2'b00) begin bad++; $display("FAIL rnd_fsm_end got=%b exp=00", state[1:0]); end
  endtask

  task automatic test_reset_midpacket();
    got_d.delete(); got_l.delete();
    tready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      streamEnable = (c == 0);
      ADC_data = 14'(c);
      tick();
    end
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL mid_pre_tvalid got=%b exp=1", tvalid); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL mid_async_tvalid got=%b exp=0", tvalid); end
    total++; if (state !== 3'b000) begin bad++; $display("FAIL mid_async_state got=%b exp=000", state); end
    total++; if (tdata !== 32'h0) begin bad++; $display("FAIL mid_async_tdata got=%h exp=00000000", tdata); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tready = 1'b1;
    test_ramp();
  endtask

  initial begin
    rst = 1'b1;
    streamEnable = 1'b0; testMode = 1'b0;
    ADC_data = '0; ADC_otr = 1'b0; tready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_ramp();
    test_convert();
    test_testmode();
    test_overflow();
    do_reset();
    test_random_ready();
    do_reset();
    test_reset_midpacket();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
